// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   W_FUNC / W_DATA : function-code and datapath widths
//   FUNC_*          : function codes recognised by ex_muldiv (MADD family only
//                     acts when MULDIV_MADD_EN is defined)
//   muldiv_state_t  : sequencer states
//   mag32()         : magnitude of a possibly-signed 32-bit operand
package ex_muldiv_pkg;

  localparam int unsigned W_FUNC = 6;
  localparam int unsigned W_DATA = 32;

  localparam logic [W_FUNC-1:0] FUNC_MTHI  = 6'h11;
  localparam logic [W_FUNC-1:0] FUNC_MTLO  = 6'h13;
  localparam logic [W_FUNC-1:0] FUNC_MULT  = 6'h18;
  localparam logic [W_FUNC-1:0] FUNC_MULTU = 6'h19;
  localparam logic [W_FUNC-1:0] FUNC_DIV   = 6'h1A;
  localparam logic [W_FUNC-1:0] FUNC_DIVU  = 6'h1B;
  localparam logic [W_FUNC-1:0] FUNC_MADD  = 6'h1C;
  localparam logic [W_FUNC-1:0] FUNC_MADDU = 6'h1D;
  localparam logic [W_FUNC-1:0] FUNC_MSUB  = 6'h1E;
  localparam logic [W_FUNC-1:0] FUNC_MSUBU = 6'h1F;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ACC,
    DIV,
    FIX,
    COMMIT
  } muldiv_state_t;

  function automatic logic [W_DATA-1:0] mag32(input logic [W_DATA-1:0] x,
                                              input logic              is_signed);
    return (is_signed && x[W_DATA-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-facing bundle of the multiply/divide unit.
//   start, func, source_a, source_b, flush : from EX control / operand select
//   stall, done, hi, lo                    : back to the pipeline
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic              start;
  logic [W_FUNC-1:0] func;
  logic [W_DATA-1:0] source_a;
  logic [W_DATA-1:0] source_b;
  logic              flush;
  logic              stall;
  logic              done;
  logic [W_DATA-1:0] hi;
  logic [W_DATA-1:0] lo;

  modport master (
    output start, func, source_a, source_b, flush,
    input  stall, done, hi, lo
  );

  modport slave (
    input  start, func, source_a, source_b, flush,
    output stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_divider.sv
// 32-step unsigned radix-2 restoring divider.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : load operands (restarts any division in progress)
//   dividend_i    : unsigned dividend
//   divisor_i     : unsigned divisor
//   busy_o        : iteration in progress
//   quotient_o    : quotient, valid once busy_o has dropped
//   remainder_o   : remainder, valid once busy_o has dropped
// A zero divisor needs no special case: every trial subtraction succeeds, so
// the quotient fills with ones and the remainder ends up equal to the dividend.
module muldiv_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [5:0]  cnt_q;
  logic [32:0] shifted, diff;

  // Partial remainder shifted left with the next dividend bit, and the trial subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= 6'd32;
    end else if (cnt_q != 6'd0) begin
      cnt_q <= cnt_q - 6'd1;
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign busy_o      = (cnt_q != 6'd0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   md_io      : ex_muldiv_if.slave -- start/func/source_a/source_b/flush in,
//                stall/done/hi/lo out
// Parameter MUL_LATENCY (>=1): cycles a multiply spends in MUL after acceptance.
// Build option MULDIV_MADD_EN: decode MADD/MADDU/MSUB/MSUBU (multiply then
// accumulate into {hi,lo} through one extra ACC cycle). Without it those codes
// are ignored like any other unrecognised func.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave md_io
);

  muldiv_state_t state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;

  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        sgn_q, acc_q, sub_q, div_op_q;
  logic [63:0] res_q;
  logic [63:0] pipe_q [MUL_LATENCY];

  // Decode of the incoming func.
  logic is_mul, is_div, is_madd, is_signed, is_sub, is_mthi, is_mtlo;
  logic long_op, accept, launch;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_madd   = 1'b0;
    is_signed = 1'b0;
    is_sub    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (md_io.func)
      FUNC_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      FUNC_MULTU: is_mul = 1'b1;
      FUNC_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      FUNC_DIVU:  is_div = 1'b1;
      FUNC_MTHI:  is_mthi = 1'b1;
      FUNC_MTLO:  is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      FUNC_MADD:  begin is_madd = 1'b1; is_signed = 1'b1; end
      FUNC_MADDU: is_madd = 1'b1;
      FUNC_MSUB:  begin is_madd = 1'b1; is_signed = 1'b1; is_sub = 1'b1; end
      FUNC_MSUBU: begin is_madd = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // COMMIT can take a fresh op because HI/LO are written before it is needed;
  // flush always wins over start.
  assign long_op = is_mul | is_div | is_madd;
  assign accept  = md_io.start & ~md_io.flush & ((state_q == IDLE) | (state_q == COMMIT));
  assign launch  = accept & long_op;

  assign md_io.stall = ((state_q != IDLE) & (state_q != COMMIT)) |
                       (md_io.start & long_op & (state_q == IDLE));
  assign md_io.done  = (state_q == COMMIT);
  assign md_io.hi    = hi_q;
  assign md_io.lo    = lo_q;

  // Sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      MUL: begin
        if (cnt_q == 6'(MUL_LATENCY - 1)) begin
          state_d = acc_q ? ACC : COMMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ACC: state_d = COMMIT;
      DIV: begin
        if (cnt_q == 6'd31) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      FIX:    state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = is_div ? DIV : MUL;
      cnt_d   = '0;
    end
    // A commit already in COMMIT is not undone; every other state is abandoned.
    if (md_io.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier: operands extended to 64 bits so one product serves both signednesses.
  logic [63:0] mul_a, mul_b, mul_p, pipe_out;
  assign mul_a    = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b    = {{32{sgn_q & b_q[31]}}, b_q};
  assign mul_p    = mul_a * mul_b;
  assign pipe_out = pipe_q[MUL_LATENCY-1];

  // Divider works on magnitudes; signs are restored in FIX.
  logic        div_busy;
  logic [31:0] div_quo, div_rem;

  muldiv_divider u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (launch & is_div),
    .dividend_i  (mag32(md_io.source_a, is_signed)),
    .divisor_i   (mag32(md_io.source_b, is_signed)),
    .busy_o      (div_busy),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  logic [63:0] fix_res;
  always_comb begin
    fix_res = {((sgn_q & a_q[31]) ? (~div_rem + 32'd1) : div_rem),
               ((sgn_q & (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo)};
    if (b_q == '0) begin
      fix_res = {a_q, 32'hFFFF_FFFF};
    end
  end

  logic [63:0] commit_val;
  assign commit_val = (div_op_q | acc_q) ? res_q : pipe_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= 1'b0;
      sub_q    <= 1'b0;
      div_op_q <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      if (launch) begin
        a_q      <= md_io.source_a;
        b_q      <= md_io.source_b;
        sgn_q    <= is_signed;
        acc_q    <= is_madd;
        sub_q    <= is_sub;
        div_op_q <= is_div;
      end
      if (state_q == MUL) begin
        pipe_q[0] <= mul_p;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
      if (state_q == ACC) begin
        res_q <= sub_q ? ({hi_q, lo_q} - pipe_out) : ({hi_q, lo_q} + pipe_out);
      end
      if (state_q == FIX) begin
        res_q <= fix_res;
      end
      if (state_q == COMMIT) begin
        {hi_q, lo_q} <= commit_val;
      end
      // A move accepted in the COMMIT cycle is younger than the commit, so it wins.
      if (accept & is_mthi) begin
        hi_q <= md_io.source_a;
      end
      if (accept & is_mtlo) begin
        lo_q <= md_io.source_a;
      end
    end
  end

  // The sequencer counts divide iterations itself; the core must agree.
  assert property (@(posedge clk) disable iff (!rst_n) (state_q == DIV) |-> div_busy);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int unsigned MUL_LAT = 2;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_if md ();

  ex_muldiv #(.MUL_LATENCY(MUL_LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_io (md)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_long(input logic [5:0] f);
    case (f)
      FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: return 1'b1;
      FUNC_MADD, FUNC_MADDU, FUNC_MSUB, FUNC_MSUBU: return MADD_EN;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from acceptance to the commit cycle.
  function automatic int op_cycles(input logic [5:0] f);
    if (f == FUNC_DIV || f == FUNC_DIVU) return 34;
    if (f == FUNC_MULT || f == FUNC_MULTU) return MUL_LAT + 1;
    return MUL_LAT + 2;
  endfunction

  function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      FUNC_MULT:  return sa * sb;
      FUNC_MULTU: return ua * ub;
      FUNC_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FUNC_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      FUNC_MADD:  return hl + sa * sb;
      FUNC_MADDU: return hl + ua * ub;
      FUNC_MSUB:  return hl - sa * sb;
      FUNC_MSUBU: return hl - ua * ub;
      default:    return hl;
    endcase
  endfunction

  // An in-flight op is tracked only by its age and the age at which it commits.
  logic        m_busy;
  int          m_age, m_n;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_n    <= 0;
      m_res  <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin : model_step
      logic [63:0] hl;
      logic        busy;
      int          age;
      hl   = {m_hi, m_lo};
      busy = m_busy;
      age  = m_age + 1;
      if (m_busy && m_age == m_n) begin
        hl   = m_res;
        busy = 1'b0;
      end
      if (md.flush) busy = 1'b0;
      if (md.start && !md.flush && !(m_busy && m_age != m_n)) begin
        if (is_long(md.func)) begin
          busy = 1'b1;
          age  = 1;
          m_n   <= op_cycles(md.func);
          m_res <= model_result(md.func, md.source_a, md.source_b, hl);
        end else if (md.func == FUNC_MTHI) begin
          hl[63:32] = md.source_a;
        end else if (md.func == FUNC_MTLO) begin
          hl[31:0] = md.source_a;
        end
      end
      m_busy <= busy;
      m_age  <= age;
      m_hi   <= hl[63:32];
      m_lo   <= hl[31:0];
    end
  end

  logic exp_stall, exp_done;
  assign exp_stall = (m_busy && m_age < m_n) || (md.start && is_long(md.func) && !m_busy);
  assign exp_done  = m_busy && m_age == m_n;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cyc_stall", {63'b0, md.stall}, {63'b0, exp_stall});
      check("cyc_done",  {63'b0, md.done},  {63'b0, exp_done});
      check("cyc_hi",    {32'b0, md.hi},    {32'b0, m_hi});
      check("cyc_lo",    {32'b0, md.lo},    {32'b0, m_lo});
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int done_at);
    n_stall = 0;
    done_at = -1;
    @(posedge clk); #1;
    md.start = 1'b1; md.func = f; md.source_a = a; md.source_b = b;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (md.stall) n_stall++;
      if (md.done) done_at = c;
      if (done_at < 0) begin
        @(posedge clk); #1;
        md.start = 1'b0;
      end
    end
    md.start = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic run_short(input string name, input logic [5:0] f, input logic [31:0] a);
    @(posedge clk); #1;
    md.start = 1'b1; md.func = f; md.source_a = a; md.source_b = 32'h0;
    @(negedge clk);
    check(name, {63'b0, md.stall}, 64'd0);
    @(posedge clk); #1;
    md.start = 1'b0;
  endtask

  int ns, da, ndone;

  initial begin
    md.start = 1'b0; md.func = '0; md.source_a = '0; md.source_b = '0; md.flush = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'b0, md.hi}, 64'd0);
    check("rst_lo", {32'b0, md.lo}, 64'd0);
    check("rst_done", {63'b0, md.done}, 64'd0);
    check("rst_stall_idle", {63'b0, md.stall}, 64'd0);
    md.start = 1'b1; md.func = FUNC_MULT; #1;
    check("rst_stall_long", {63'b0, md.stall}, 64'd1);
    md.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(FUNC_MULT, 32'hFFFF_FFFE, 32'd3, ns, da);
    check("mult_stall_cycles", 64'(ns), 64'd3);
    check("mult_done_cycle", 64'(da), 64'd3);
    settle();
    check("mult_hi", {32'b0, md.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'b0, md.lo}, 64'hFFFF_FFFA);

    run_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, da);
    settle();
    check("multu_hi", {32'b0, md.hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'b0, md.lo}, 64'h0000_0001);

    run_op(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, ns, da);
    check("div_stall_cycles", 64'(ns), 64'd34);
    check("div_done_cycle", 64'(da), 64'd34);
    settle();
    check("div_lo", {32'b0, md.lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'b0, md.hi}, 64'hFFFF_FFFF);

    run_op(FUNC_DIVU, 32'd7, 32'd0, ns, da);
    settle();
    check("divu0_lo", {32'b0, md.lo}, 64'hFFFF_FFFF);
    check("divu0_hi", {32'b0, md.hi}, 64'd7);

    run_op(FUNC_DIVU, 32'd1000, 32'd7, ns, da);
    settle();
    check("divu_lo", {32'b0, md.lo}, 64'd142);
    check("divu_hi", {32'b0, md.hi}, 64'd6);

    // Overflow case, then MTHI in the cycle right after the commit.
    run_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ns, da);
    @(posedge clk); #1;
    md.start = 1'b1; md.func = FUNC_MTHI; md.source_a = 32'h1234;
    @(negedge clk);
    check("mthi_stall", {63'b0, md.stall}, 64'd0);
    check("divov_lo", {32'b0, md.lo}, 64'h8000_0000);
    check("divov_hi", {32'b0, md.hi}, 64'd0);
    @(posedge clk); #1;
    md.start = 1'b0;
    @(negedge clk);
    check("mthi_hi", {32'b0, md.hi}, 64'h1234);

    // Flush in cycle 10 of a divide.
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin
        @(posedge clk); #1;
        md.func = FUNC_DIV; md.source_a = 32'd100; md.source_b = 32'd7;
      end
      md.start = (c == 0);
      md.flush = (c == 10);
      @(negedge clk);
      if (c == 10) check("flush_stall_c10", {63'b0, md.stall}, 64'd1);
      if (c == 11) check("flush_stall_c11", {63'b0, md.stall}, 64'd0);
      if (md.done) ndone++;
      @(posedge clk); #1;
    end
    md.flush = 1'b0;
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hi", {32'b0, md.hi}, 64'h1234);
    check("flush_lo", {32'b0, md.lo}, 64'h8000_0000);

    // flush together with start: nothing accepted.
    md.start = 1'b1; md.func = FUNC_MULT; md.source_a = 32'd5; md.source_b = 32'd5;
    md.flush = 1'b1;
    @(posedge clk); #1;
    md.start = 1'b0; md.flush = 1'b0;
    @(negedge clk);
    check("flushstart_stall", {63'b0, md.stall}, 64'd0);

    // MTLO accepted in the COMMIT cycle of a multiply overrides the committed LO.
    @(posedge clk); #1;
    md.start = 1'b1; md.func = FUNC_MULTU; md.source_a = 32'd5; md.source_b = 32'd7;
    @(posedge clk); #1;
    md.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    md.start = 1'b1; md.func = FUNC_MTLO; md.source_a = 32'h55;
    @(negedge clk);
    check("commit_done", {63'b0, md.done}, 64'd1);
    @(posedge clk); #1;
    md.start = 1'b0;
    @(negedge clk);
    check("commit_mtlo_lo", {32'b0, md.lo}, 64'h55);
    check("commit_mtlo_hi", {32'b0, md.hi}, 64'd0);

    run_short("other_stall", 6'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    check("other_lo", {32'b0, md.lo}, 64'h55);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    md.start = 1'b1; md.func = FUNC_MULT; md.source_a = 32'd9; md.source_b = 32'd9;
    @(posedge clk); #1;
    md.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hi", {32'b0, md.hi}, 64'd0);
    check("midrst_lo", {32'b0, md.lo}, 64'd0);
    check("midrst_stall", {63'b0, md.stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(FUNC_MULTU, 32'd3, 32'd4, ns, da);
    check("postrst_done_cycle", 64'(da), 64'(MUL_LAT + 1));
    settle();
    check("postrst_lo", {32'b0, md.lo}, 64'd12);

    // Multiply-accumulate.
    run_short("mthi0_stall", FUNC_MTHI, 32'd0);
    run_short("mtlo5_stall", FUNC_MTLO, 32'd5);
    run_op(FUNC_MADD, 32'd2, 32'd3, ns, da);
    settle();
    if (MADD_EN) begin
      check("madd_stall_cycles", 64'(ns), 64'(MUL_LAT + 2));
      check("madd_lo", {32'b0, md.lo}, 64'd11);
      check("madd_hi", {32'b0, md.hi}, 64'd0);
      run_op(FUNC_MSUBU, 32'd1, 32'd20, ns, da);
      settle();
      check("msubu_lo", {32'b0, md.lo}, 64'hFFFF_FFF7);
      check("msubu_hi", {32'b0, md.hi}, 64'hFFFF_FFFF);
    end else begin
      check("madd_off_stall", 64'(ns), 64'd0);
      check("madd_off_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
      check("madd_off_lo", {32'b0, md.lo}, 64'd5);
    end

    // Model self-pins against hand-computed results.
    check("model_mult", model_result(FUNC_MULT, 32'hFFFF_FFFE, 32'd3, 64'd0),
          64'hFFFF_FFFF_FFFF_FFFA);
    check("model_div", model_result(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0),
          64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divov", model_result(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0),
          64'h0000_0000_8000_0000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
